// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Purpose  : Assigns incoming note-on/note-off events to a pool of synth
//             voices. One event is processed at a time. The allocator scans
//             one voice per cycle, then applies the result in a single commit
//             cycle. Each voice keeps an age rank; 0 is the most recently
//             allocated voice.
//  Options  : Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice when
//             every voice is busy. Without it, such note-ons are dropped and
//             ev_dropped pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    output logic [VOICES-1:0]     voice_gate,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [7*VOICES-1:0]   voice_vel,
    output logic                  voice_stolen,
    output logic                  ev_dropped
);

    localparam int              c_iw       = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(VOICES - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_scan   = 2'd1;
    localparam logic [1:0] c_commit = 2'd2;

`ifdef VOICE_ALLOCATOR_STEAL_EN
    localparam logic c_steal_en = 1'b1;
`else
    localparam logic c_steal_en = 1'b0;
`endif

    // Controller state and the latched event
    logic [1:0]      r_state;
    logic [c_iw-1:0] r_idx;
    logic            r_on;
    logic [6:0]      r_ev_note;
    logic [6:0]      r_ev_vel;

    // Results gathered during the scan
    logic            r_match_found;
    logic [c_iw-1:0] r_match_idx;
    logic            r_free_found;
    logic [c_iw-1:0] r_free_idx;
    logic [c_iw-1:0] r_oldest_idx;

    // Per-voice state
    logic [VOICES-1:0] r_gate;
    logic [6:0]        r_note_arr [VOICES];
    logic [6:0]        r_vel_arr  [VOICES];
    logic [c_iw-1:0]   r_rank     [VOICES];
    logic              r_stolen;
    logic              r_dropped;

    // Commit decisions
    logic            w_do_load;
    logic            w_do_off;
    logic            w_steal;
    logic            w_drop;
    logic [c_iw-1:0] w_target;

    // Reset has priority so that no event can be accepted while it is held.
    assign ev_ready     = (r_state == c_idle) && !reset;
    assign voice_gate   = r_gate;
    assign voice_stolen = r_stolen;
    assign ev_dropped   = r_dropped;

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_pack
        assign voice_note[7*gi +: 7] = r_note_arr[gi];
        assign voice_vel[7*gi +: 7]  = r_vel_arr[gi];
    end

    // Sequence each event through accept, scan, and commit.
    // Record the lowest matching voice, the lowest free voice, and the oldest voice.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_idx         <= '0;
            r_on          <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (ev_valid && ev_ready) begin
                        // A velocity of zero is handled as a note-off.
                        r_on          <= ev_on && (ev_vel != 7'd0);
                        r_ev_note     <= ev_note;
                        r_ev_vel      <= ev_vel;
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_state       <= c_scan;
                    end
                end
                c_scan: begin
                    // Voices are scanned from index 0 upward.
                    // The first hit in each category is therefore the lowest index.
                    if (r_gate[r_idx] && (r_note_arr[r_idx] == r_ev_note) && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_gate[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (r_rank[r_idx] == c_last_idx) begin
                        r_oldest_idx <= r_idx;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= c_commit;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_commit: r_state <= c_idle;
                default:  r_state <= c_idle;
            endcase
        end
    end

    // Choose the target voice and the action for the commit cycle.
    always_comb begin
        w_target  = r_match_idx;
        w_do_load = 1'b0;
        w_do_off  = 1'b0;
        w_steal   = 1'b0;
        w_drop    = 1'b0;
        if (r_on) begin
            if (r_match_found) begin
                w_do_load = 1'b1;
            end else if (r_free_found) begin
                w_target  = r_free_idx;
                w_do_load = 1'b1;
            end else if (c_steal_en) begin
                w_target  = r_oldest_idx;
                w_do_load = 1'b1;
                w_steal   = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else if (r_match_found) begin
            w_do_off = 1'b1;
        end
    end

    // Voice state changes only on the commit edge.
    // The status pulses are high for the single cycle that follows the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate    <= '0;
            r_stolen  <= 1'b0;
            r_dropped <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                r_note_arr[i] <= '0;
                r_vel_arr[i]  <= '0;
                r_rank[i]     <= c_iw'(i);
            end
        end else begin
            r_stolen  <= 1'b0;
            r_dropped <= 1'b0;
            if (r_state == c_commit) begin
                r_stolen  <= w_steal;
                r_dropped <= w_drop;
                if (w_do_load) begin
                    r_gate[w_target]     <= 1'b1;
                    r_note_arr[w_target] <= r_ev_note;
                    r_vel_arr[w_target]  <= r_ev_vel;
                    // The target becomes the newest voice.
                    // Voices that were newer than the target each age by one rank.
                    for (int i = 0; i < VOICES; i++) begin
                        if (c_iw'(i) == w_target) begin
                            r_rank[i] <= '0;
                        end else if (r_rank[i] < r_rank[w_target]) begin
                            r_rank[i] <= r_rank[i] + 1'b1;
                        end
                    end
                end
                if (w_do_off) begin
                    r_gate[w_target] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_allocator
//  Purpose  : Directed, self-checking bench for voice_allocator (VOICES = 8).
//             Expected values depend on VOICE_ALLOCATOR_STEAL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int VOICES = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ev_valid = 1'b0;
    logic                ev_ready;
    logic                ev_on = 1'b0;
    logic [6:0]          ev_note = '0;
    logic [6:0]          ev_vel = '0;
    logic [VOICES-1:0]   voice_gate;
    logic [7*VOICES-1:0] voice_note;
    logic [7*VOICES-1:0] voice_vel;
    logic                voice_stolen;
    logic                ev_dropped;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stolen_seen  = 0;
    int n_dropped_seen = 0;

    voice_allocator #(.VOICES(VOICES)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .voice_gate   (voice_gate),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .voice_stolen (voice_stolen),
        .ev_dropped   (ev_dropped)
    );

    always #5 clk = ~clk;

    // Count every pulse, so that spurious pulses are detected as well.
    always @(negedge clk) begin
        if (voice_stolen) n_stolen_seen++;
        if (ev_dropped)   n_dropped_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int i);
        return voice_vel[7*i +: 7];
    endfunction

    // Count the busy cycles until ev_ready returns.
    // The count is capped so that the bench always terminates.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (!ev_ready) n++;
        end while (!ev_ready && n < 40);
    endtask

    // Offer one event for one cycle, then wait for the allocator to become ready again.
    task automatic send(input logic on, input logic [6:0] nt, input logic [6:0] v, output int busy);
        int g;
        g = 0;
        while (!ev_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = nt;
        ev_vel   = v;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        count_busy(busy);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", ev_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    int busy;
    int s0;
    int d0;
    logic [7*VOICES-1:0] snap_note;
    logic [7*VOICES-1:0] snap_vel;

    initial begin
        // Reset values
        do_reset();
        chk("rst_ready", ev_ready, 1'b1);
        chk("rst_gate", voice_gate, 8'h00);
        chk("rst_note", voice_note, 56'h0);
        chk("rst_vel", voice_vel, 56'h0);
        chk("rst_pulses", {voice_stolen, ev_dropped}, 2'b00);

        // Single note-on
        send(1'b1, 7'd60, 7'd100, busy);
        chk("lat_busy", busy, 9);
        chk("on_gate", voice_gate, 8'h01);
        chk("on_note0", note_of(0), 7'd60);
        chk("on_vel0", vel_of(0), 7'd100);

        // Note-off frees a middle voice, and the next note-on reuses that voice.
        do_reset();
        send(1'b1, 7'd60, 7'd10, busy);
        send(1'b1, 7'd64, 7'd20, busy);
        send(1'b1, 7'd67, 7'd30, busy);
        send(1'b0, 7'd64, 7'd0, busy);
        chk("off_gate", voice_gate, 8'h05);
        chk("off_note1", note_of(1), 7'd64);
        chk("off_vel1", vel_of(1), 7'd20);
        send(1'b1, 7'd72, 7'd40, busy);
        chk("reuse_gate", voice_gate, 8'h07);
        chk("reuse_note1", note_of(1), 7'd72);
        chk("reuse_vel1", vel_of(1), 7'd40);
        // A note-on with velocity 0 acts as a note-off.
        send(1'b1, 7'd67, 7'd0, busy);
        chk("vel0_gate", voice_gate, 8'h03);
        chk("vel0_note2", note_of(2), 7'd67);

        // All voices busy, then one more note-on arrives.
        do_reset();
        for (int k = 0; k < 8; k++) send(1'b1, 7'(40 + k), 7'(1 + k), busy);
        chk("full_gate", voice_gate, 8'hFF);
        snap_note = voice_note;
        snap_vel  = voice_vel;
        s0 = n_stolen_seen;
        d0 = n_dropped_seen;
        send(1'b1, 7'd50, 7'd77, busy);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        chk("steal_pulse", voice_stolen, 1'b1);
        chk("steal_note0", note_of(0), 7'd50);
        chk("steal_vel0", vel_of(0), 7'd77);
        chk("steal_gate", voice_gate, 8'hFF);
        // Voice 1 is now the oldest voice.
        send(1'b1, 7'd51, 7'd78, busy);
        chk("steal2_note1", note_of(1), 7'd51);
        chk("steal2_note0", note_of(0), 7'd50);
        @(negedge clk);
        chk("steal_count", n_stolen_seen - s0, 2);
        chk("steal_nodrop", n_dropped_seen - d0, 0);
`else
        chk("drop_pulse", ev_dropped, 1'b1);
        chk("drop_note", voice_note, snap_note);
        chk("drop_vel", voice_vel, snap_vel);
        chk("drop_gate", voice_gate, 8'hFF);
        chk("drop_note0", note_of(0), 7'd40);
        @(negedge clk);
        chk("drop_once", ev_dropped, 1'b0);
        chk("drop_count", n_dropped_seen - d0, 1);
        chk("drop_nosteal", n_stolen_seen - s0, 0);
`endif

        // ev_valid held high for back-to-back events: a retrigger, then an unmatched note-off.
        do_reset();
        s0 = n_stolen_seen;
        d0 = n_dropped_seen;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd60;
        ev_vel   = 7'd100;
        @(posedge clk);
        count_busy(busy);
        chk("hold_busy1", busy, 9);
        @(posedge clk);
        count_busy(busy);
        chk("hold_busy2", busy, 9);
        chk("retrig_gate", voice_gate, 8'h01);
        chk("retrig_note1", note_of(1), 7'd0);
        ev_on   = 1'b0;
        ev_note = 7'd99;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        count_busy(busy);
        chk("hold_busy3", busy, 9);
        chk("nomatch_gate", voice_gate, 8'h01);
        chk("nomatch_note0", note_of(0), 7'd60);
        @(negedge clk);
        chk("nomatch_pulses", (n_stolen_seen - s0) + (n_dropped_seen - d0), 0);

        // Reset in the fourth scan cycle aborts the event.
        send(1'b1, 7'd64, 7'd50, busy);
        chk("pre_abort_gate", voice_gate, 8'h03);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd70;
        ev_vel   = 7'd90;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_low", ev_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", ev_ready, 1'b1);
        chk("abort_gate", voice_gate, 8'h00);
        chk("abort_note", voice_note, 56'h0);
        chk("abort_vel", voice_vel, 56'h0);
        repeat (12) @(negedge clk);
        chk("abort_no_late", {voice_gate, ev_ready}, {8'h00, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
